// File: rtl/cond_exec_unit.sv
// Execute-stage conditional-execution unit: holds the NZCV flags register,
// evaluates the instruction condition, annuls failed instructions, sequences
// pipeline flushes on a taken redirect and counts annulled instructions.
module cond_exec_unit #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned COUNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         CondE,
    input  logic [1:0]         FlagWriteE,
    input  logic [3:0]         ALUFlags,
    input  logic               PCSrcE,
    input  logic               RegWriteE,
    input  logic               MemWriteE,
    input  logic               BranchE,
    output logic               PCSrcG,
    output logic               RegWriteG,
    output logic               MemWriteG,
    output logic               BranchTakenE,
    output logic               CondExE,
    output logic [3:0]         FlagsOut,
    output logic               FlushD,
    output logic               FlushE,
    output logic [COUNT_W-1:0] AnnulCount
);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    localparam logic [3:0] RELOAD = 4'(FLUSH_CYCLES - 1);

    logic [3:0]         flags;
    logic               n, z, c, v;
    logic               redirect;
    logic               annul;
    state_t             state, next_state;
    logic [3:0]         cnt, next_cnt;
    logic [COUNT_W-1:0] annul_count;

    assign n = flags[3];
    assign z = flags[2];
    assign c = flags[1];
    assign v = flags[0];

    // Condition evaluation against the registered (pre-edge) flags
    always_comb begin
        CondExE = 1'b0;
        unique case (CondE)
            4'h0: CondExE = z;
            4'h1: CondExE = ~z;
            4'h2: CondExE = c;
            4'h3: CondExE = ~c;
            4'h4: CondExE = n;
            4'h5: CondExE = ~n;
            4'h6: CondExE = v;
            4'h7: CondExE = ~v;
            4'h8: CondExE = c & ~z;
            4'h9: CondExE = ~c | z;
            4'hA: CondExE = (n == v);
            4'hB: CondExE = (n != v);
            4'hC: CondExE = ~z & (n == v);
            4'hD: CondExE = z | (n != v);
            default: CondExE = 1'b1;
        endcase
    end

    assign PCSrcG       = PCSrcE & CondExE;
    assign RegWriteG    = RegWriteE & CondExE;
    assign MemWriteG    = MemWriteE & CondExE;
    assign BranchTakenE = BranchE & CondExE;
    assign redirect     = CondExE & (PCSrcE | BranchE);
    assign annul        = ~CondExE & (PCSrcE | RegWriteE | MemWriteE | BranchE | (|FlagWriteE));
    assign FlagsOut     = flags;
    assign AnnulCount   = annul_count;

    // Flags register: each half loads independently, only for passing instructions
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= '0;
        end else if (CondExE) begin
            if (FlagWriteE[1]) flags[3:2] <= ALUFlags[3:2];
            if (FlagWriteE[0]) flags[1:0] <= ALUFlags[1:0];
        end
    end

    // Flush FSM state and down-counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Flush FSM next state and flush outputs; a new redirect restarts the window
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        unique case (state)
            IDLE: begin
                if (redirect) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        next_state = FLUSH;
                        next_cnt   = RELOAD;
                    end
                end
            end
            FLUSH: begin
                FlushD = 1'b1;
                if (redirect) begin
                    FlushE   = 1'b1;
                    next_cnt = RELOAD;
                end else if (cnt <= 4'd1) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt - 4'd1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Saturating count of annulled (non-bubble) instructions
    always_ff @(posedge clk) begin
        if (reset) begin
            annul_count <= '0;
        end else if (annul && (annul_count != '1)) begin
            annul_count <= annul_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Bench for cond_exec_unit: two instances (16-bit and 2-bit annul counters)
// driven in lockstep, a per-cycle reference model and directed literal checks.
module tb_cond_exec_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] CondE;
    logic [1:0] FlagWriteE;
    logic [3:0] ALUFlags;
    logic       PCSrcE, RegWriteE, MemWriteE, BranchE;

    logic        PCSrcG, RegWriteG, MemWriteG, BranchTakenE, CondExE, FlushD, FlushE;
    logic [3:0]  FlagsOut;
    logic [15:0] AnnulCount;

    logic        d2_PCSrcG, d2_RegWriteG, d2_MemWriteG, d2_BranchTakenE, d2_CondExE, d2_FlushD, d2_FlushE;
    logic [3:0]  d2_FlagsOut;
    logic [1:0]  d2_AnnulCount;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cond_exec_unit #(.FLUSH_CYCLES(2), .COUNT_W(16)) dut (
        .clk(clk), .reset(reset), .CondE(CondE), .FlagWriteE(FlagWriteE), .ALUFlags(ALUFlags),
        .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
        .PCSrcG(PCSrcG), .RegWriteG(RegWriteG), .MemWriteG(MemWriteG), .BranchTakenE(BranchTakenE),
        .CondExE(CondExE), .FlagsOut(FlagsOut), .FlushD(FlushD), .FlushE(FlushE), .AnnulCount(AnnulCount)
    );

    cond_exec_unit #(.FLUSH_CYCLES(2), .COUNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .CondE(CondE), .FlagWriteE(FlagWriteE), .ALUFlags(ALUFlags),
        .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
        .PCSrcG(d2_PCSrcG), .RegWriteG(d2_RegWriteG), .MemWriteG(d2_MemWriteG), .BranchTakenE(d2_BranchTakenE),
        .CondExE(d2_CondExE), .FlagsOut(d2_FlagsOut), .FlushD(d2_FlushD), .FlushE(d2_FlushE), .AnnulCount(d2_AnnulCount)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", nm, $time, act, exp);
        end
    endtask

    // Reference model state: flags as separate booleans, flush window as
    // "FlushD cycles still owed", counts as plain integers.
    bit m_n, m_z, m_c, m_v;
    int m_owed;
    int m_cnt16, m_cnt2;

    function automatic bit cond_ok(input int cc, input bit fn, input bit fz, input bit fc, input bit fv);
        case (cc)
            0:  return fz;
            1:  return !fz;
            2:  return fc;
            3:  return !fc;
            4:  return fn;
            5:  return !fn;
            6:  return fv;
            7:  return !fv;
            8:  return fc && !fz;
            9:  return !fc || fz;
            10: return fn == fv;
            11: return fn != fv;
            12: return !fz && (fn == fv);
            13: return fz || (fn != fv);
            default: return 1'b1;
        endcase
    endfunction

    // Compare process: check both instances against the model mid-cycle, then advance the model
    initial begin
        bit ok, r, any;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_n = 0; m_z = 0; m_c = 0; m_v = 0;
                m_owed = 0; m_cnt16 = 0; m_cnt2 = 0;
            end else begin
                ok  = cond_ok(int'(CondE), m_n, m_z, m_c, m_v);
                r   = ok && (PCSrcE || BranchE);
                any = PCSrcE || RegWriteE || MemWriteE || BranchE || (FlagWriteE != 2'b00);
                chk("m_cond",    int'(CondExE),      int'(ok));
                chk("m_pcsrc",   int'(PCSrcG),       int'(PCSrcE && ok));
                chk("m_regw",    int'(RegWriteG),    int'(RegWriteE && ok));
                chk("m_memw",    int'(MemWriteG),    int'(MemWriteE && ok));
                chk("m_br",      int'(BranchTakenE), int'(BranchE && ok));
                chk("m_flushd",  int'(FlushD),       int'(r || m_owed > 0));
                chk("m_flushe",  int'(FlushE),       int'(r));
                chk("m_flags",   int'(FlagsOut),     int'({m_n, m_z, m_c, m_v}));
                chk("m_cnt16",   int'(AnnulCount),   m_cnt16);
                chk("m2_cond",   int'(d2_CondExE),   int'(ok));
                chk("m2_gated",  int'({d2_PCSrcG, d2_RegWriteG, d2_MemWriteG, d2_BranchTakenE}),
                    int'({PCSrcE && ok, RegWriteE && ok, MemWriteE && ok, BranchE && ok}));
                chk("m2_flush",  int'({d2_FlushD, d2_FlushE}), int'({r || m_owed > 0, r}));
                chk("m2_flags",  int'(d2_FlagsOut),  int'({m_n, m_z, m_c, m_v}));
                chk("m2_cnt2",   int'(d2_AnnulCount), m_cnt2);
                if (ok && FlagWriteE[1]) begin m_n = ALUFlags[3]; m_z = ALUFlags[2]; end
                if (ok && FlagWriteE[0]) begin m_c = ALUFlags[1]; m_v = ALUFlags[0]; end
                if (r) m_owed = 1;            // FLUSH_CYCLES-1 further FlushD cycles
                else if (m_owed > 0) m_owed--;
                if (!ok && any) begin
                    if (m_cnt16 < 65535) m_cnt16++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic [3:0] cc, input logic [1:0] fw, input logic [3:0] alu,
                       input logic pc, input logic rw, input logic mw, input logic br);
        CondE = cc; FlagWriteE = fw; ALUFlags = alu;
        PCSrcE = pc; RegWriteE = rw; MemWriteE = mw; BranchE = br;
        #1;
    endtask

    task automatic bubble();
        set(4'hE, 2'b00, 4'h0, 0, 0, 0, 0);
    endtask

    logic [3:0] flag_pats [4] = '{4'b0000, 4'b0110, 4'b1001, 4'b1111};

    // Directed stimulus with hand-computed expectations
    initial begin
        reset = 1'b1;
        bubble();
        step(); step();
        reset = 1'b0;
        chk("reset_flags", int'(FlagsOut), 0);
        chk("reset_cnt", int'(AnnulCount), 0);
        chk("reset_flushd", int'(FlushD), 0);

        // 1: AL with full flag write
        set(4'hE, 2'b11, 4'b0100, 0, 0, 0, 0);
        chk("t1_condex", int'(CondExE), 1);
        step();
        chk("t1_flags", int'(FlagsOut), 4'b0100);

        // 2: NE fails with Z=1
        set(4'h1, 2'b00, 4'h0, 0, 1, 1, 0);
        chk("t2_regw", int'(RegWriteG), 0);
        chk("t2_memw", int'(MemWriteG), 0);
        chk("t2_cnt0", int'(AnnulCount), 0);
        step();
        chk("t2_cnt1", int'(AnnulCount), 1);

        // 3: failed EQ must not write flags
        set(4'hE, 2'b11, 4'b0000, 0, 0, 0, 0); step();
        set(4'h0, 2'b11, 4'b1111, 0, 0, 0, 0); step();
        chk("t3_kept", int'(FlagsOut), 0);
        set(4'hE, 2'b11, 4'b1111, 0, 0, 0, 0); step();
        chk("t3_written", int'(FlagsOut), 4'b1111);

        // Independent halves: only C,V written
        set(4'hE, 2'b01, 4'b0000, 0, 0, 0, 0); step();
        chk("half_cv", int'(FlagsOut), 4'b1100);

        // 4: LT taken with N=0,V=1
        set(4'hE, 2'b11, 4'b0001, 0, 0, 0, 0); step();
        set(4'hB, 2'b00, 4'h0, 0, 0, 0, 1);
        chk("t4_taken", int'(BranchTakenE), 1);
        chk("t4_fd0", int'(FlushD), 1);
        chk("t4_fe0", int'(FlushE), 1);
        step(); bubble();
        chk("t4_fd1", int'(FlushD), 1);
        chk("t4_fe1", int'(FlushE), 0);
        step();
        chk("t4_fd2", int'(FlushD), 0);
        chk("t4_fe2", int'(FlushE), 0);

        // 5: back-to-back taken branches restart the window
        set(4'hE, 2'b00, 4'h0, 1, 0, 0, 0); step();
        set(4'hE, 2'b00, 4'h0, 0, 0, 0, 1);
        chk("t5_fe", int'(FlushE), 1);
        chk("t5_fd", int'(FlushD), 1);
        step(); bubble();
        chk("t5_fd1", int'(FlushD), 1);
        chk("t5_fe1", int'(FlushE), 0);
        step();
        chk("t5_fd2", int'(FlushD), 0);

        // All conditions against several flag patterns (model-checked)
        for (int unsigned p = 0; p < 4; p++) begin
            set(4'hE, 2'b11, flag_pats[p], 0, 0, 0, 0); step();
            for (int unsigned cc = 0; cc < 16; cc++) begin
                set(4'(cc), 2'b00, 4'h0, 0, 1, 0, 0); step();
            end
        end
        // GT with N=1,Z=0,C=0,V=1 passes; LE fails
        set(4'hE, 2'b11, 4'b1001, 0, 0, 0, 0); step();
        set(4'hC, 2'b00, 4'h0, 0, 1, 0, 0);
        chk("gt_pass", int'(CondExE), 1);
        set(4'hD, 2'b00, 4'h0, 0, 1, 0, 0);
        chk("le_fail", int'(CondExE), 0);
        step();

        // 6: saturation of the 2-bit counter, bubbles not counted
        reset = 1'b1; bubble(); step(); reset = 1'b0;
        set(4'h0, 2'b00, 4'h0, 0, 0, 1, 0); step();
        chk("t6_c1", int'(d2_AnnulCount), 1);
        step();
        chk("t6_c2", int'(d2_AnnulCount), 2);
        set(4'h0, 2'b00, 4'h0, 0, 0, 0, 0); step();
        chk("t6_bubble", int'(d2_AnnulCount), 2);
        set(4'h0, 2'b00, 4'h0, 0, 0, 1, 0); step();
        chk("t6_c3", int'(d2_AnnulCount), 3);
        step();
        chk("t6_sat", int'(d2_AnnulCount), 3);
        chk("t6_wide", int'(AnnulCount), 4);

        // Reset while in FLUSH, with a same-cycle flag write
        set(4'hE, 2'b00, 4'h0, 0, 0, 0, 1); step();
        reset = 1'b1;
        set(4'hE, 2'b11, 4'b1111, 0, 0, 0, 0); step();
        reset = 1'b0; bubble();
        chk("t6_rst_cnt", int'(d2_AnnulCount), 0);
        chk("t6_rst_flags", int'(FlagsOut), 0);
        chk("t6_rst_fd", int'(FlushD), 0);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
